tmc_nios2_timer_master: RTL and testbench

Hardware Avalon-MM initiator that drives the 16-bit interval-timer slave without processor involvement. It programs the 32-bit period and starts, stops and snapshots the timer, and reads the 32-bit snapshot back. It also services the timer interrupt by clearing its status. It sits between TMC control logic, which issues single-cycle commands, and the timer's s1 slave port.

---
 rtl/tmc_nios2_timer_master.sv | 173 +++++++++++++++++
 tb/tb_tmc_nios2_timer_master.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tmc_nios2_timer_master.sv
// tmc_nios2_timer_master
//   Avalon-MM initiator that runs the interval-timer s1 slave on behalf of
//   TMC control logic: programs the 32-bit period and starts the timer,
//   stops it, snapshots and reads back the counter, and clears the timeout
//   status when the timer interrupt is raised.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   cmd_load/cmd_period load period then start (period sampled on accept)
//   cmd_stop            stop the timer
//   cmd_snap            snapshot counter and read it back
//   busy                high while a sequence is in flight
//   snap_valid          one-cycle strobe, snap_value just updated
//   snap_value          last snapshot {hi, lo}
//   timeout_pulse       one-cycle strobe per serviced interrupt
//   irq                 timer interrupt (level)
//   address, chipselect, write_n, writedata, readdata
//                       Avalon-MM master side, read latency 1, no waitrequest
module tmc_nios2_timer_master #(
  parameter logic CONTINUOUS = 1'b1,
  parameter logic IRQ_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_load,
  input  logic [31:0] cmd_period,
  input  logic        cmd_stop,
  input  logic        cmd_snap,
  output logic        busy,
  output logic        snap_valid,
  output logic [31:0] snap_value,
  output logic        timeout_pulse,
  input  logic        irq,
  output logic [2:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic [15:0] writedata,
  input  logic [15:0] readdata
);

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_PER_L  = 3'd2;
  localparam logic [2:0] A_PER_H  = 3'd3;
  localparam logic [2:0] A_SNAP_L = 3'd4;
  localparam logic [2:0] A_SNAP_H = 3'd5;

  // control word {STOP, START, CONT, ITO}
  localparam logic [15:0] CTL_START = {12'h0, 1'b0, 1'b1, CONTINUOUS, IRQ_EN};
  localparam logic [15:0] CTL_STOP  = {12'h0, 1'b1, 1'b0, CONTINUOUS, IRQ_EN};

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTL, WR_STOP, CLR_ST, WR_SNAP, RD_SL, RD_SH, RD_DONE
  } state_t;

  state_t      state_q;
  logic [15:0] period_hi_q;   // low half goes straight onto the bus on accept
  logic [15:0] snap_lo_q;
  logic        busy_q, snap_valid_q, timeout_pulse_q;
  logic [31:0] snap_value_q;
  logic [2:0]  address_q;
  logic        chipselect_q, write_n_q;
  logic [15:0] writedata_q;

  assign busy          = busy_q;
  assign snap_valid    = snap_valid_q;
  assign snap_value    = snap_value_q;
  assign timeout_pulse = timeout_pulse_q;
  assign address       = address_q;
  assign chipselect    = chipselect_q;
  assign write_n       = write_n_q;
  assign writedata     = writedata_q;

  // Bus outputs are registered on the transition into the state they belong
  // to, so every case arm loads the values for the *next* state. Anything not
  // overridden falls back to the idle bus and cleared strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      period_hi_q     <= '0;
      snap_lo_q       <= '0;
      busy_q          <= 1'b0;
      snap_valid_q    <= 1'b0;
      snap_value_q    <= '0;
      timeout_pulse_q <= 1'b0;
      address_q       <= '0;
      chipselect_q    <= 1'b0;
      write_n_q       <= 1'b1;
      writedata_q     <= '0;
    end else begin
      snap_valid_q    <= 1'b0;
      timeout_pulse_q <= 1'b0;
      address_q       <= '0;
      chipselect_q    <= 1'b0;
      write_n_q       <= 1'b1;
      writedata_q     <= '0;
      busy_q          <= 1'b1;

      case (state_q)
        IDLE: begin
          // fixed priority; losers are dropped, irq is a level so it waits
          if (irq) begin
            state_q         <= CLR_ST;
            chipselect_q    <= 1'b1;
            write_n_q       <= 1'b0;
            address_q       <= A_STATUS;
            timeout_pulse_q <= 1'b1;
          end else if (cmd_stop) begin
            state_q      <= WR_STOP;
            chipselect_q <= 1'b1;
            write_n_q    <= 1'b0;
            address_q    <= A_CTRL;
            writedata_q  <= CTL_STOP;
          end else if (cmd_load) begin
            state_q      <= WR_PL;
            period_hi_q  <= cmd_period[31:16];
            chipselect_q <= 1'b1;
            write_n_q    <= 1'b0;
            address_q    <= A_PER_L;
            writedata_q  <= cmd_period[15:0];
          end else if (cmd_snap) begin
            state_q      <= WR_SNAP;
            chipselect_q <= 1'b1;
            write_n_q    <= 1'b0;
            address_q    <= A_SNAP_L;
          end else begin
            busy_q <= 1'b0;
          end
        end
        WR_PL: begin
          state_q      <= WR_PH;
          chipselect_q <= 1'b1;
          write_n_q    <= 1'b0;
          address_q    <= A_PER_H;
          writedata_q  <= period_hi_q;
        end
        WR_PH: begin
          state_q      <= WR_CTL;
          chipselect_q <= 1'b1;
          write_n_q    <= 1'b0;
          address_q    <= A_CTRL;
          writedata_q  <= CTL_START;
        end
        WR_SNAP: begin
          state_q      <= RD_SL;
          chipselect_q <= 1'b1;
          address_q    <= A_SNAP_L;
        end
        RD_SL: begin
          state_q      <= RD_SH;
          chipselect_q <= 1'b1;
          address_q    <= A_SNAP_H;
        end
        RD_SH: begin
          // data for the RD_SL read arrives one cycle after its address
          state_q   <= RD_DONE;
          snap_lo_q <= readdata;
        end
        RD_DONE: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          snap_value_q <= {readdata, snap_lo_q};
          snap_valid_q <= 1'b1;
        end
        default: begin  // WR_CTL, WR_STOP, CLR_ST are single-cycle
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmc_nios2_timer_master.sv
module tb_tmc_nios2_timer_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_load = 1'b0, cmd_stop = 1'b0, cmd_snap = 1'b0;
  logic [31:0] cmd_period = '0;
  logic        busy, snap_valid, timeout_pulse;
  logic [31:0] snap_value;
  logic        irq;
  logic [2:0]  address;
  logic        chipselect, write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  int checks = 0, failures = 0, cyc = 0, pulses = 0;

  always #5 clk = ~clk;

  tmc_nios2_timer_master dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_load(cmd_load), .cmd_period(cmd_period), .cmd_stop(cmd_stop), .cmd_snap(cmd_snap),
    .busy(busy), .snap_valid(snap_valid), .snap_value(snap_value),
    .timeout_pulse(timeout_pulse), .irq(irq),
    .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata)
  );

  // ---------------- timer slave model ----------------
  logic        fire = 1'b0;          // one-cycle request to raise the timeout
  logic        to_q = 1'b0;
  logic [15:0] ctl_q = '0, pl_q = '0, ph_q = '0, rd_q = '0;
  logic [31:0] snap_q = '0, cnt = 32'hDEAD_BEEF;

  assign irq = to_q;
  assign readdata = rd_q;

  always @(posedge clk) begin
    if (fire) to_q <= 1'b1;
    if (chipselect && !write_n) begin
      case (address)
        3'd0: to_q <= 1'b0;          // clear wins over a coincident timeout
        3'd1: ctl_q <= writedata;
        3'd2: pl_q <= writedata;
        3'd3: ph_q <= writedata;
        3'd4, 3'd5: snap_q <= cnt;
        default: ;
      endcase
    end
    if (chipselect && write_n)
      rd_q <= (address == 3'd4) ? snap_q[15:0] : (address == 3'd5) ? snap_q[31:16] : 16'h0;
    else
      rd_q <= 16'h0;
  end

  // ---------------- behavioural model: expected per-cycle outputs ----------------
  typedef struct {
    logic        cs, wn;
    logic [2:0]  a;
    logic [15:0] wd;
    logic        busy, tp, sv;
    logic [31:0] snap;
  } rec_t;

  rec_t exp_q[$];
  rec_t cur;
  logic [31:0] exp_snap = '0;

  function automatic rec_t mk(logic cs, logic wn, logic [2:0] a, logic [15:0] wd,
                              logic b, logic tp, logic sv, logic [31:0] s);
    rec_t r;
    r.cs = cs; r.wn = wn; r.a = a; r.wd = wd; r.busy = b; r.tp = tp; r.sv = sv; r.snap = s;
    return r;
  endfunction

  function automatic logic [15:0] ctl_word(logic stop, logic start);
    return 16'(8 * int'(stop) + 4 * int'(start) + 2 + 1);  // CONT=1, ITO=1
  endfunction

  // Single compare process, mid-cycle: inputs for the coming edge are stable.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      exp_q.delete();
      exp_snap = '0;
      cur = mk(0, 1, 0, 0, 0, 0, 0, 0);
    end else begin
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = mk(0, 1, 0, 0, 0, 0, 0, 0);
      if (cur.sv) exp_snap = cur.snap;
    end
    checks++;
    if (chipselect !== cur.cs || write_n !== cur.wn || address !== cur.a ||
        writedata !== cur.wd || busy !== cur.busy || timeout_pulse !== cur.tp ||
        snap_valid !== cur.sv || snap_value !== exp_snap) begin
      failures++;
      $display("FAIL cycle%0d outputs: got cs=%b wn=%b a=%0d wd=%h busy=%b tp=%b sv=%b sval=%h want cs=%b wn=%b a=%0d wd=%h busy=%b tp=%b sv=%b sval=%h",
               cyc, chipselect, write_n, address, writedata, busy, timeout_pulse, snap_valid, snap_value,
               cur.cs, cur.wn, cur.a, cur.wd, cur.busy, cur.tp, cur.sv, exp_snap);
    end
    if (timeout_pulse) pulses++;
    // acceptance: only when the model is idle this cycle
    if (reset_n && !cur.busy && exp_q.size() == 0) begin
      if (irq) begin
        exp_q.push_back(mk(1, 0, 0, 16'h0, 1, 1, 0, 0));
      end else if (cmd_stop) begin
        exp_q.push_back(mk(1, 0, 1, ctl_word(1, 0), 1, 0, 0, 0));
      end else if (cmd_load) begin
        exp_q.push_back(mk(1, 0, 2, cmd_period[15:0], 1, 0, 0, 0));
        exp_q.push_back(mk(1, 0, 3, cmd_period[31:16], 1, 0, 0, 0));
        exp_q.push_back(mk(1, 0, 1, ctl_word(0, 1), 1, 0, 0, 0));
      end else if (cmd_snap) begin
        exp_q.push_back(mk(1, 0, 4, 16'h0, 1, 0, 0, 0));
        exp_q.push_back(mk(1, 1, 4, 16'h0, 1, 0, 0, 0));
        exp_q.push_back(mk(1, 1, 5, 16'h0, 1, 0, 0, 0));
        exp_q.push_back(mk(0, 1, 0, 16'h0, 1, 0, 0, 0));
        exp_q.push_back(mk(0, 1, 0, 16'h0, 0, 0, 1, cnt));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic pulse_cmd(logic l, logic s, logic st, logic f, logic [31:0] p);
    @(posedge clk); #1;
    cmd_load = l; cmd_snap = s; cmd_stop = st; fire = f; cmd_period = p;
    @(posedge clk); #1;
    cmd_load = 0; cmd_snap = 0; cmd_stop = 0; fire = 0;
  endtask

  task automatic lit16(string name, logic [15:0] got, logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    // reset held while commands and a timeout toggle: no bus activity
    #1;
    pulse_cmd(1, 0, 0, 0, 32'h1111_2222);
    pulse_cmd(0, 1, 1, 1, 32'h0);           // timeout raised during reset
    idle(2);
    lit16("no_write_in_reset", ctl_q, 16'h0000);
    @(posedge clk); #1 reset_n = 1'b1;     // pending irq is serviced first
    idle(4);

    // load
    pulse_cmd(1, 0, 0, 0, 32'h0001_2345);
    cmd_period = 32'hFFFF_FFFF;            // must not disturb the load
    idle(4);
    lit16("period_l", pl_q, 16'h2345);
    lit16("period_h", ph_q, 16'h0001);
    lit16("ctl_start", ctl_q, 16'h0007);

    // snapshot
    pulse_cmd(0, 1, 0, 0, 32'h0);
    idle(7);
    lit16("snap_lo", snap_value[15:0], 16'hBEEF);
    lit16("snap_hi", snap_value[31:16], 16'hDEAD);

    // interrupt service
    pulse_cmd(0, 0, 0, 1, 32'h0);
    idle(5);
    lit16("irq_cleared", {15'h0, irq}, 16'h0000);

    // stop, then snap while busy is dropped
    pulse_cmd(0, 0, 1, 0, 32'h0);
    cmd_snap = 1; @(posedge clk); #1 cmd_snap = 0;
    idle(4);
    lit16("ctl_stop", ctl_q, 16'h000B);

    // irq + load + snap together: only the clear
    @(posedge clk); #1 fire = 1;
    @(posedge clk); #1 fire = 0;
    pulse_cmd(1, 1, 0, 0, 32'h5555_AAAA);
    idle(8);
    lit16("load_dropped", pl_q, 16'h2345);

    // second snapshot with a different counter, followed directly by a load
    cnt = 32'h1234_5678;
    pulse_cmd(0, 1, 0, 0, 32'h0);
    idle(4);
    cmd_load = 1; cmd_period = 32'h0002_0010;
    @(posedge clk); #1 cmd_load = 0;
    idle(5);
    lit16("snap2_lo", snap_value[15:0], 16'h5678);
    lit16("load2_l", pl_q, 16'h0010);

    // reset pulsed during WR_PH: no WR_CTL, sequence abandoned
    pulse_cmd(1, 0, 0, 0, 32'hCAFE_0001);   // ends 1 ns into WR_PL
    @(posedge clk); #1 reset_n = 1'b0;      // now inside WR_PH
    @(posedge clk); #1 reset_n = 1'b1;
    idle(5);
    lit16("abort_pl", pl_q, 16'h0001);
    lit16("abort_ph", ph_q, 16'h0002);
    lit16("abort_ctl", ctl_q, 16'h0007);

    lit16("pulse_count", 16'(pulses), 16'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
